// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex 7-segment driver for a common-anode display.
// Latches display data on load and scans one digit per slot, with a one-cycle dead time at each slot start.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int SCAN_DIV    = 50000,
  parameter int BLINK_SCANS = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   hex_in,
  input  logic [DIGITS-1:0]     point_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic [DIGITS-1:0]     blink_in,
  output logic [6:0]            seg_n,
  output logic                  dp_n,
  output logic [DIGITS-1:0]     an_n,
  output logic                  frame_done
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int KW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int BW = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

  localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
  localparam logic [KW-1:0] K_LAST = KW'(DIGITS - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_SCANS - 1);

  logic [4*DIGITS-1:0] hex_q;
  logic [DIGITS-1:0]   point_q;
  logic [DIGITS-1:0]   blank_q;
  logic [DIGITS-1:0]   blink_q;

  logic [PW-1:0] p;
  logic [KW-1:0] k;
  logic [BW-1:0] blink_cnt;
  logic          phase;

  logic              slot_end;
  logic              frame_wrap;
  logic [3:0]        cur_hex;
  logic              cur_point;
  logic              cur_blank;
  logic              cur_blink;
  logic [DIGITS-1:0] cur_sel;
  logic              driven;
  logic [6:0]        seg_d;
  logic              dp_d;
  logic [DIGITS-1:0] an_d;

  // Lit-segment pattern, bit0 = a ... bit6 = g.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h3F;
      4'h1: s = 7'h06;
      4'h2: s = 7'h5B;
      4'h3: s = 7'h4F;
      4'h4: s = 7'h66;
      4'h5: s = 7'h6D;
      4'h6: s = 7'h7D;
      4'h7: s = 7'h07;
      4'h8: s = 7'h7F;
      4'h9: s = 7'h6F;
      4'hA: s = 7'h77;
      4'hB: s = 7'h7C;
      4'hC: s = 7'h39;
      4'hD: s = 7'h5E;
      4'hE: s = 7'h79;
      default: s = 7'h71;
    endcase
    return s;
  endfunction

  assign slot_end   = (p == P_LAST);
  assign frame_wrap = slot_end && (k == K_LAST);

  // Digit select by comparison keeps indexing in range for non-power-of-two digit counts.
  always_comb begin
    cur_hex   = 4'h0;
    cur_point = 1'b0;
    cur_blank = 1'b0;
    cur_blink = 1'b0;
    cur_sel   = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (k == KW'(i)) begin
        cur_hex    = hex_q[4*i +: 4];
        cur_point  = point_q[i];
        cur_blank  = blank_q[i];
        cur_blink  = blink_q[i];
        cur_sel[i] = 1'b1;
      end
    end
  end

  always_comb begin
    driven = (p != '0) && !cur_blank && !(cur_blink && phase);
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    an_d   = '1;
    if (driven) begin
      seg_d = ~decode(cur_hex);
      dp_d  = ~cur_point;
      an_d  = ~cur_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hex_q      <= '0;
      point_q    <= '0;
      blank_q    <= '0;
      blink_q    <= '0;
      p          <= '0;
      k          <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b0;
      seg_n      <= 7'h7F;
      dp_n       <= 1'b1;
      an_n       <= '1;
      frame_done <= 1'b0;
    end else begin
      if (load) begin
        hex_q   <= hex_in;
        point_q <= point_in;
        blank_q <= blank_in;
        blink_q <= blink_in;
      end

      if (slot_end) begin
        p <= '0;
        k <= (k == K_LAST) ? '0 : k + 1'b1;
      end else begin
        p <= p + 1'b1;
      end

      // Blink phase advances only on whole frames so every digit sees the same blink timing.
      if (frame_wrap) begin
        if (blink_cnt == B_LAST) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 1'b1;
        end
      end

      seg_n      <= seg_d;
      dp_n       <= dp_d;
      an_n       <= an_d;
      frame_done <= frame_wrap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances cover the 4-digit scan, the single-digit
// decode table, and blinking on a 2-digit display.
module tb_seg7_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A: DIGITS=4, SCAN_DIV=4
  logic        rst_a, load_a;
  logic [15:0] hex_a;
  logic [3:0]  point_a, blank_a, blink_a;
  logic [6:0]  seg_a;
  logic        dp_a, fd_a;
  logic [3:0]  an_a;

  // Instance B: DIGITS=1, SCAN_DIV=2
  logic        rst_b, load_b;
  logic [3:0]  hex_b;
  logic [0:0]  point_b, blank_b, blink_b;
  logic [6:0]  seg_b;
  logic        dp_b, fd_b;
  logic [0:0]  an_b;

  // Instance C: DIGITS=2, SCAN_DIV=3, BLINK_SCANS=2
  logic        rst_c, load_c;
  logic [7:0]  hex_c;
  logic [1:0]  point_c, blank_c, blink_c;
  logic [6:0]  seg_c;
  logic        dp_c, fd_c;
  logic [1:0]  an_c;

  seg7_scan_driver #(.DIGITS(4), .SCAN_DIV(4), .BLINK_SCANS(64)) u_a (
    .clk(clk), .rst(rst_a), .load(load_a), .hex_in(hex_a), .point_in(point_a),
    .blank_in(blank_a), .blink_in(blink_a), .seg_n(seg_a), .dp_n(dp_a), .an_n(an_a),
    .frame_done(fd_a));

  seg7_scan_driver #(.DIGITS(1), .SCAN_DIV(2), .BLINK_SCANS(64)) u_b (
    .clk(clk), .rst(rst_b), .load(load_b), .hex_in(hex_b), .point_in(point_b),
    .blank_in(blank_b), .blink_in(blink_b), .seg_n(seg_b), .dp_n(dp_b), .an_n(an_b),
    .frame_done(fd_b));

  seg7_scan_driver #(.DIGITS(2), .SCAN_DIV(3), .BLINK_SCANS(2)) u_c (
    .clk(clk), .rst(rst_c), .load(load_c), .hex_in(hex_c), .point_in(point_c),
    .blank_in(blank_c), .blink_in(blink_c), .seg_n(seg_c), .dp_n(dp_c), .an_n(an_c),
    .frame_done(fd_c));

  int checks = 0;
  int errors = 0;
  // Non-reset edges since each instance's last reset edge.
  int n_a = 0;
  int n_b = 0;
  int n_c = 0;

  logic [6:0] a_seg [4];
  logic       a_dp [4];
  logic       a_dark [4];
  logic [6:0] b_seg;

  // Active-low segment codes for 0..F, worked out by hand from the lit-segment table.
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  task check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task tick;
    @(posedge clk);
    if (rst_a) n_a = 0; else n_a++;
    if (rst_b) n_b = 0; else n_b++;
    if (rst_c) n_c = 0; else n_c++;
    #1;
  endtask

  task check_a(input string tag);
    int idx, slot, pos;
    logic [3:0] an_e;
    logic [6:0] seg_e;
    logic       dp_e, fd_e;
    an_e = 4'hF; seg_e = 7'h7F; dp_e = 1'b1; fd_e = 1'b0;
    if (n_a > 0) begin
      idx  = n_a - 1;
      slot = (idx / 4) % 4;
      pos  = idx % 4;
      fd_e = (idx % 16 == 15);
      if (pos != 0 && !a_dark[slot]) begin
        an_e  = ~(4'b0001 << slot);
        seg_e = a_seg[slot];
        dp_e  = a_dp[slot];
      end
    end
    check_output({tag, ".a.an"}, 32'(an_a), 32'(an_e));
    check_output({tag, ".a.seg"}, 32'(seg_a), 32'(seg_e));
    check_output({tag, ".a.dp"}, 32'(dp_a), 32'(dp_e));
    check_output({tag, ".a.fd"}, 32'(fd_a), 32'(fd_e));
  endtask

  task check_b(input string tag);
    logic drv;
    drv = (n_b > 0) && ((n_b - 1) % 2 == 1);
    check_output({tag, ".b.an"}, 32'(an_b), drv ? 32'd0 : 32'd1);
    check_output({tag, ".b.seg"}, 32'(seg_b), drv ? 32'(b_seg) : 32'h7F);
    check_output({tag, ".b.dp"}, 32'(dp_b), 32'd1);
    check_output({tag, ".b.fd"}, 32'(fd_b), drv ? 32'd1 : 32'd0);
  endtask

  task check_c(input string tag);
    int idx, slot, pos, ph;
    logic [1:0] an_e;
    logic [6:0] seg_e;
    logic       fd_e;
    an_e = 2'b11; seg_e = 7'h7F; fd_e = 1'b0;
    if (n_c > 0) begin
      idx  = n_c - 1;
      slot = (idx / 3) % 2;
      pos  = idx % 3;
      ph   = (idx / 12) % 2;
      fd_e = (idx % 6 == 5);
      if (pos != 0 && !(slot == 1 && ph == 1)) begin
        an_e  = (slot == 1) ? 2'b01 : 2'b10;
        seg_e = (slot == 1) ? 7'h24 : 7'h79;
      end
    end
    check_output({tag, ".c.an"}, 32'(an_c), 32'(an_e));
    check_output({tag, ".c.seg"}, 32'(seg_c), 32'(seg_e));
    check_output({tag, ".c.dp"}, 32'(dp_c), 32'd1);
    check_output({tag, ".c.fd"}, 32'(fd_c), 32'(fd_e));
  endtask

  task apply_stimulus_init;
    rst_a = 1'b1; load_a = 1'b0; hex_a = '0; point_a = '0; blank_a = '0; blink_a = '0;
    rst_b = 1'b1; load_b = 1'b0; hex_b = '0; point_b = '0; blank_b = '0; blink_b = '0;
    rst_c = 1'b1; load_c = 1'b0; hex_c = 8'h21; point_c = '0; blank_c = '0; blink_c = 2'b10;
    for (int i = 0; i < 4; i++) begin
      a_seg[i] = 7'h40; a_dp[i] = 1'b1; a_dark[i] = 1'b0;
    end
    b_seg = 7'h40;
  endtask

  initial begin
    apply_stimulus_init();

    repeat (3) begin
      tick();
      check_a("reset"); check_b("reset"); check_c("reset");
    end

    // Release all resets; C captures its data on the first (dead-time) edge.
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; load_c = 1'b1;
    tick();
    load_c = 1'b0;
    check_a("scan"); check_b("scan"); check_c("scan");
    repeat (47) begin
      tick();
      check_a("scan"); check_b("scan"); check_c("blink");
    end

    // Decode table through the single-digit instance.
    for (int v = 0; v < 16; v++) begin
      hex_b = 4'(v); load_b = 1'b1;
      tick();
      check_b("dec_ldedge");
      load_b = 1'b0; b_seg = seg_tab[v];
      tick(); check_b("dec");
      tick(); check_b("dec");
    end

    // Mixed blank/point pattern on the 4-digit instance.
    hex_a = 16'h1234; point_a = 4'b0100; blank_a = 4'b0001; load_a = 1'b1;
    tick();
    check_a("pat_ldedge");
    load_a = 1'b0;
    a_dark[0] = 1'b1; a_seg[1] = 7'h30; a_seg[2] = 7'h24; a_seg[3] = 7'h79; a_dp[2] = 1'b0;
    repeat (16) begin
      tick();
      check_a("pattern");
    end

    // Reset in the middle of the digit-2 slot.
    for (int i = 0; i < 16; i++) begin
      if (n_a > 0 && ((n_a - 1) / 4) % 4 == 2 && (n_a - 1) % 4 == 1) break;
      tick();
    end
    check_output("pre_rst.an", 32'(an_a), 32'hB);
    rst_a = 1'b1;
    tick();
    check_a("midrst");
    rst_a = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_seg[i] = 7'h40; a_dp[i] = 1'b1; a_dark[i] = 1'b0;
    end
    repeat (6) begin
      tick();
      check_a("after_rst");
    end

    // Load mid-slot on the active digit: 5 -> A.
    hex_a = 16'h0005; point_a = '0; blank_a = '0; load_a = 1'b1;
    tick();
    check_a("ld5_edge");
    load_a = 1'b0; a_seg[0] = 7'h12;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_a("ld5");
      if ((n_a - 1) % 16 == 1) break;
    end
    hex_a = 16'h000A; load_a = 1'b1;
    tick();
    check_a("ldA_edge");
    load_a = 1'b0; a_seg[0] = 7'h08;
    tick();
    check_a("ldA_new");
    tick();
    check_a("ldA_dead");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
